// File: rtl/multdiv_unit.sv
// Iterative signed 32x32 multiply (radix-2 shift-add) and signed 32/32
// divide (restoring). The operation runs on operand magnitudes and the sign is
// applied on the completion edge. A start pulse in any state aborts the current
// operation and restarts it.
module multdiv_unit (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   // hi: product high word or partial remainder
   // lo: multiplier shifting out and product low word, or dividend shifting out and quotient shifting in
   // op: multiplicand or divisor magnitude
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] op_q, op_d;
   logic        neg_q, neg_d;
   logic [31:0] result_q, result_d;
   logic        exc_q, exc_d;

   logic        start;
   logic [31:0] mag_a, mag_b;
   logic [32:0] msum, rshift, rdiff;
   logic [63:0] prod;
   logic [31:0] quot;

   // Next-state, datapath iteration and completion logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      exc_d    = exc_q;

      start  = ctrl_MULT | ctrl_DIV;
      mag_a  = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
      mag_b  = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
      msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : 33'd0);
      // Remainder stays below the divisor, so the shifted value fits in 33 bits
      // and rdiff[32] is the borrow.
      rshift = {hi_q, lo_q[31]};
      rdiff  = rshift - {1'b0, op_q};
      prod   = neg_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
      quot   = neg_q ? (32'd0 - lo_q) : lo_q;

      if (start) begin
         state_d = ctrl_MULT ? S_MULT : S_DIV;
         cnt_d   = 6'd0;
         hi_d    = 32'd0;
         lo_d    = mag_a;
         op_d    = mag_b;
         neg_d   = data_operandA[31] ^ data_operandB[31];
      end else begin
         case (state_q)
            S_MULT: begin
               if (cnt_q == 6'd32) begin
                  state_d  = S_DONE;
                  result_d = prod[31:0];
                  exc_d    = ~((&prod[63:31]) | ~(|prod[63:31]));
               end else begin
                  hi_d  = msum[32:1];
                  lo_d  = {msum[0], lo_q[31:1]};
                  cnt_d = cnt_q + 6'd1;
               end
            end
            S_DIV: begin
               if (op_q == 32'd0) begin
                  state_d  = S_DONE;
                  result_d = 32'd0;
                  exc_d    = 1'b1;
               end else if (cnt_q == 6'd32) begin
                  state_d  = S_DONE;
                  result_d = quot;
                  // Only 0x80000000 / -1 yields a positive quotient of 2^31
                  exc_d    = lo_q[31] & ~neg_q;
               end else begin
                  if (!rdiff[32]) begin
                     hi_d = rdiff[31:0];
                     lo_d = {lo_q[30:0], 1'b1};
                  end else begin
                     hi_d = rshift[31:0];
                     lo_d = {lo_q[30:0], 1'b0};
                  end
                  cnt_d = cnt_q + 6'd1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 6'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         op_q     <= 32'd0;
         neg_q    <= 1'b0;
         result_q <= 32'd0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == S_DONE);
   assign busy           = (state_q == S_MULT) || (state_q == S_DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed cases, restart/reset behaviour and
// randomized operations against a plain-arithmetic reference model.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int tests = 0;
   int fails = 0;

   multdiv_unit dut (
      .clock(clock), .reset_n(reset_n),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy)
   );

   always #5 clock = ~clock;

   // Reference model: signed arithmetic on 64-bit integers
   function automatic void model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic exc, output int lat);
      longint p;
      int     q;
      lat = 33;
      if (is_mult) begin
         p   = longint'($signed(a)) * longint'($signed(b));
         res = p[31:0];
         exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end else if (b == 32'd0) begin
         res = 32'd0; exc = 1'b1; lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         res = 32'h8000_0000; exc = 1'b1;
      end else begin
         q   = $signed(a) / $signed(b);
         res = q; exc = 1'b0;
      end
   endfunction

   // Called at a negedge: present a start, pass edge 0, then scramble operands
   task automatic do_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = $urandom; data_operandB = $urandom;
   endtask

   // Count edges after edge 0 until resultRDY is seen (sampled at negedge)
   task automatic wait_done(output int n, output logic ok);
      n = 0; ok = 1'b0;
      while (!ok && n < 60) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (data_resultRDY) ok = 1'b1;
      end
   endtask

   task automatic run_check(input string name, input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er; logic ee; int el; int n; logic ok;
      model(m, a, b, er, ee, el);
      do_start(m, d, a, b);
      wait_done(n, ok);
      tests++;
      if (!ok || n !== el) begin
         fails++;
         $display("FAIL %s latency: got %0d (seen=%0b) expected %0d a=%h b=%h", name, n, ok, el, a, b);
      end
      tests++;
      if (data_result !== er || data_exception !== ee) begin
         fails++;
         $display("FAIL %s value a=%h b=%h: got %h exc=%b expected %h exc=%b",
                  name, a, b, data_result, data_exception, er, ee);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #2;
      tests++;
      if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b expected all 0",
                  data_result, data_exception, data_resultRDY, busy);
      end
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_directed;
      run_check("mult_7x-6", 1, 0, 32'd7, 32'hFFFF_FFFA);
      tests++;
      if (data_result !== 32'hFFFF_FFD6) begin
         fails++;
         $display("FAIL mult_7x-6_const: got %h expected ffffffd6", data_result);
      end
      run_check("mult_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000);
      run_check("mult_max", 1, 0, 32'h7FFF_FFFF, 32'd1);
      run_check("div_-43/5", 0, 1, 32'hFFFF_FFD5, 32'd5);
      tests++;
      if (data_result !== 32'hFFFF_FFF8) begin
         fails++;
         $display("FAIL div_-43/5_const: got %h expected fffffff8", data_result);
      end
      run_check("div_by_zero", 0, 1, 32'd100, 32'd0);
      run_check("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_check("both_starts", 1, 1, 32'd6, 32'd7);
   endtask

   task automatic test_busy_hold;
      int n; logic ok; logic [31:0] r;
      do_start(1, 0, 32'd9, 32'd11);
      @(negedge clock);
      tests++;
      if (busy !== 1'b1 || data_resultRDY !== 1'b0) begin
         fails++;
         $display("FAIL busy_running: got busy=%b rdy=%b expected 1 0", busy, data_resultRDY);
      end
      wait_done(n, ok);
      tests++;
      if (!ok || busy !== 1'b0 || data_result !== 32'd99) begin
         fails++;
         $display("FAIL busy_done: got ok=%b busy=%b res=%h expected 1 0 00000063", ok, busy, data_result);
      end
      r = data_result;
      data_operandA = 32'h1234; data_operandB = 32'h5678;
      @(negedge clock);
      @(negedge clock);
      tests++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== 32'd99) begin
         fails++;
         $display("FAIL hold_after_done: got rdy=%b busy=%b res=%h expected 0 0 00000063",
                  data_resultRDY, busy, data_result);
      end
   endtask

   task automatic test_restart;
      int pulses; int n; logic ok;
      pulses = 0;
      do_start(1, 0, 32'd3, 32'd4);
      repeat (9) begin
         @(posedge clock);
         @(negedge clock);
         if (data_resultRDY) pulses++;
      end
      do_start(0, 1, 32'd20, 32'd3);
      wait_done(n, ok);
      tests++;
      if (pulses !== 0 || !ok || n !== 33 || data_result !== 32'd6 || data_exception !== 1'b0) begin
         fails++;
         $display("FAIL restart: got early_pulses=%0d ok=%b lat=%0d res=%h exc=%b expected 0 1 33 00000006 0",
                  pulses, ok, n, data_result, data_exception);
      end
   endtask

   task automatic test_reset_mid;
      int pulses;
      pulses = 0;
      do_start(1, 0, 32'd5, 32'd5);
      repeat (15) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_async: got res=%h exc=%b rdy=%b busy=%b expected all 0",
                  data_result, data_exception, data_resultRDY, busy);
      end
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (40) begin
         @(posedge clock);
         @(negedge clock);
         if (data_resultRDY) pulses++;
      end
      tests++;
      if (pulses !== 0) begin
         fails++;
         $display("FAIL reset_mid_no_pulse: got %0d pulses expected 0", pulses);
      end
      reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      run_check("first_edge_after_reset", 1, 0, 32'd2, 32'd3);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = $urandom;
         1: v = 32'($urandom_range(0, 40)) - 32'd20;
         2: v = 32'd0;
         3: v = 32'h8000_0000;
         4: v = 32'hFFFF_FFFF;
         default: v = $urandom >> $urandom_range(0, 31);
      endcase
      return v;
   endfunction

   task automatic test_random;
      logic [31:0] a, b; int k;
      for (int i = 0; i < 40; i++) begin
         a = pick(); b = pick(); k = $urandom_range(0, 2);
         case (k)
            0: run_check("rand_mult", 1, 0, a, b);
            1: run_check("rand_div", 0, 1, a, b);
            default: run_check("rand_both", 1, 1, a, b);
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_hold();
      test_restart();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
